// File: rtl/ex_divider_pkg.sv
// Shared constants and types for the EX-stage iterative divider.
// Op encodings, FSM states and per-radix iteration counts.
package ex_divider_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam logic [6:0] DIV_ITER_R2   = 7'd64;
   localparam logic [6:0] DIV_ITER_R2_W = 7'd32;
   localparam logic [6:0] DIV_ITER_R4   = 7'd32;
   localparam logic [6:0] DIV_ITER_R4_W = 7'd16;

   function automatic logic div_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic div_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/ex_divider_div_step.sv
// One combinational restoring-division step.
// The quotient bit is returned separately; sr_o has a 0 in its LSB.
module div_step #(
   parameter int W = 64
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] sr_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] sr_o,
   output logic         q_o
);

   logic [W:0] shifted;
   logic [W:0] diff;

   // shift in the next dividend bit and trial-subtract the divisor
   always_comb begin
      shifted = {rem_i, sr_i[W-1]};
      diff    = shifted - {1'b0, dvs_i};
      q_o     = ~diff[W];
      rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];
      sr_o    = {sr_i[W-2:0], 1'b0};
   end

endmodule

// File: rtl/ex_divider.sv
// Iterative RV64M divider for the EX stage (DIV/DIVU/REM/REMU + W forms).
// Define DIV_RADIX4_EN to retire two quotient bits per cycle.
module ex_divider
   import ex_divider_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic            kill_i,
   output logic            stall_req_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

`ifdef DIV_RADIX4_EN
   localparam logic [6:0] ITER   = DIV_ITER_R4;
   localparam logic [6:0] ITER_W = DIV_ITER_R4_W;
`else
   localparam logic [6:0] ITER   = DIV_ITER_R2;
   localparam logic [6:0] ITER_W = DIV_ITER_R2_W;
`endif

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic            word_q, word_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] sr_q, sr_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [6:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            done_q, done_d;

   logic            sgn;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res;
   logic            a_neg, b_neg, b_zero, ovf;

   logic [XLEN-1:0] s1_rem, s1_sr, sr_mid;
   logic            q1;
   logic [XLEN-1:0] nx_rem, nx_sr;
   logic [XLEN-1:0] q_fix, r_fix, sel;

   div_step #(.W(XLEN)) u_step0 (
      .rem_i (rem_q),
      .sr_i  (sr_q),
      .dvs_i (dvs_q),
      .rem_o (s1_rem),
      .sr_o  (s1_sr),
      .q_o   (q1)
   );

   assign sr_mid = s1_sr | XLEN'(q1);

`ifdef DIV_RADIX4_EN
   logic [XLEN-1:0] s2_sr;
   logic            q2;

   div_step #(.W(XLEN)) u_step1 (
      .rem_i (s1_rem),
      .sr_i  (sr_mid),
      .dvs_i (dvs_q),
      .rem_o (nx_rem),
      .sr_o  (s2_sr),
      .q_o   (q2)
   );

   assign nx_sr = s2_sr | XLEN'(q2);
`else
   assign nx_rem = s1_rem;
   assign nx_sr  = sr_mid;
`endif

   // operand preparation and special-case detection for the op in EX
   always_comb begin
      sgn   = div_is_signed(op_i);
      a_ext = src1_i;
      b_ext = src2_i;
      if (word_i) begin
         a_ext = {{(XLEN-32){sgn & src1_i[31]}}, src1_i[31:0]};
         b_ext = {{(XLEN-32){sgn & src2_i[31]}}, src2_i[31:0]};
      end
      a_neg  = sgn & a_ext[XLEN-1];
      b_neg  = sgn & b_ext[XLEN-1];
      a_mag  = a_neg ? (~a_ext + 1'b1) : a_ext;
      b_mag  = b_neg ? (~b_ext + 1'b1) : b_ext;
      a_res  = word_i ? {{(XLEN-32){src1_i[31]}}, src1_i[31:0]} : src1_i;
      b_zero = word_i ? (src2_i[31:0] == 32'd0) : (src2_i == '0);
      if (word_i)
         ovf = sgn & (src1_i[31:0] == 32'h8000_0000)
               & (src2_i[31:0] == 32'hFFFF_FFFF);
      else
         ovf = sgn & (src1_i == MIN_NEG) & (src2_i == '1);
   end

   // sign fixup of the final step's quotient and remainder
   always_comb begin
      q_fix = (negq_q && dvs_q != '0) ? (~nx_sr + 1'b1) : nx_sr;
      r_fix = negr_q ? (~nx_rem + 1'b1) : nx_rem;
      sel   = div_is_rem(op_q) ? r_fix : q_fix;
      if (word_q)
         sel = {{(XLEN-32){sel[31]}}, sel[31:0]};
   end

   // next-state logic for the IDLE/BUSY/DONE sequencer
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      word_d   = word_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      rem_d    = rem_q;
      sr_d     = sr_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      if (kill_i) begin
         state_d = DIV_IDLE;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (start_i) begin
                  op_d   = op_i;
                  word_d = word_i;
                  negq_d = a_neg ^ b_neg;
                  negr_d = a_neg;
                  rem_d  = '0;
                  sr_d   = word_i ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                  dvs_d  = b_mag;
                  cnt_d  = word_i ? ITER_W : ITER;
                  if (b_zero) begin
                     state_d  = DIV_DONE;
                     done_d   = 1'b1;
                     result_d = div_is_rem(op_i) ? a_res : '1;
                  end else if (ovf) begin
                     state_d  = DIV_DONE;
                     done_d   = 1'b1;
                     result_d = div_is_rem(op_i) ? '0 : a_res;
                  end else begin
                     state_d = DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               rem_d = nx_rem;
               sr_d  = nx_sr;
               cnt_d = cnt_q - 7'd1;
               if (cnt_q == 7'd1) begin
                  state_d  = DIV_DONE;
                  done_d   = 1'b1;
                  result_d = sel;
               end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
         endcase
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= DIV_IDLE;
         op_q     <= DIV_OP_DIV;
         word_q   <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         rem_q    <= '0;
         sr_q     <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         word_q   <= word_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         rem_q    <= rem_d;
         sr_q     <= sr_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign stall_req_o = start_i & ~done_q & ~kill_i & ~rst;
   assign done_o      = done_q;
   assign result_o    = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed vectors, kill/reset
// sequences and random ops against an arithmetic reference model.
module tb_ex_divider;

`ifdef DIV_RADIX4_EN
   localparam int N64 = 32;
   localparam int N32 = 16;
`else
   localparam int N64 = 64;
   localparam int N32 = 32;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic        word_i;
   logic [63:0] src1_i;
   logic [63:0] src2_i;
   logic        kill_i;
   logic        stall_req_o;
   logic        done_o;
   logic [63:0] result_o;

   int checks = 0;
   int errors = 0;

   ex_divider #(.XLEN(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .op_i        (op_i),
      .word_i      (word_i),
      .src1_i      (src1_i),
      .src2_i      (src2_i),
      .kill_i      (kill_i),
      .stall_req_o (stall_req_o),
      .done_o      (done_o),
      .result_o    (result_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          stall;
   } vec_t;

   task automatic chk64(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // RISC-V M-extension semantics written with native arithmetic
   function automatic logic [63:0] ref_res(input logic [1:0] op,
         input logic w, input logic [63:0] a, input logic [63:0] b);
      int                sa, sb;
      int unsigned       ua, ub;
      longint            la, lb;
      longint unsigned   xa, xb;
      logic [31:0]       r32;
      logic [63:0]       r;
      if (w) begin
         sa = int'(a[31:0]);
         sb = int'(b[31:0]);
         ua = a[31:0];
         ub = b[31:0];
         r32 = '0;
         case (op)
            2'd0: if (sb == 0) r32 = '1;
                  else if (a[31:0] == 32'h8000_0000 && sb == -1) r32 = a[31:0];
                  else r32 = 32'(sa / sb);
            2'd1: r32 = (ub == 0) ? '1 : 32'(ua / ub);
            2'd2: if (sb == 0) r32 = a[31:0];
                  else if (a[31:0] == 32'h8000_0000 && sb == -1) r32 = '0;
                  else r32 = 32'(sa % sb);
            default: r32 = (ub == 0) ? ua : 32'(ua % ub);
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         la = longint'(a);
         lb = longint'(b);
         xa = a;
         xb = b;
         case (op)
            2'd0: if (lb == 0) r = '1;
                  else if (a == 64'h8000_0000_0000_0000 && lb == -1) r = a;
                  else r = 64'(la / lb);
            2'd1: r = (xb == 0) ? '1 : 64'(xa / xb);
            2'd2: if (lb == 0) r = a;
                  else if (a == 64'h8000_0000_0000_0000 && lb == -1) r = '0;
                  else r = 64'(la % lb);
            default: r = (xb == 0) ? a : 64'(xa % xb);
         endcase
      end
      return r;
   endfunction

   function automatic int ref_stall(input logic [1:0] op, input logic w,
         input logic [63:0] a, input logic [63:0] b);
      bit bz, ov;
      bz = w ? (b[31:0] == 0) : (b == 0);
      ov = (op[0] == 1'b0) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (bz || ov) return 1;
      return (w ? N32 : N64) + 1;
   endfunction

   // called just after a negedge; returns just after done_o is seen
   task automatic run_op(input logic [1:0] op, input logic w,
         input logic [63:0] a, input logic [63:0] b,
         output logic [63:0] res, output int stalls, output bit ok);
      op_i    = op;
      word_i  = w;
      src1_i  = a;
      src2_i  = b;
      start_i = 1'b1;
      stalls  = 0;
      ok      = 1'b0;
      res     = '0;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (done_o) begin
            res = result_o;
            ok  = 1'b1;
            break;
         end
         if (stall_req_o) stalls++;
         @(negedge clk);
      end
      start_i = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL timeout: done_o never rose (op %0d)", op);
      end
   endtask

   task automatic do_vec(input string nm, input logic [1:0] op,
         input logic w, input logic [63:0] a, input logic [63:0] b,
         input logic [63:0] exp, input int exp_st);
      logic [63:0] res;
      int          st;
      bit          ok;
      run_op(op, w, a, b, res, st, ok);
      if (ok) begin
         chk64({nm, "_res"}, res, exp);
         chk_int({nm, "_stall"}, st, exp_st);
         @(negedge clk);
         chk_int({nm, "_done_pulse"}, int'(done_o), 0);
      end
   endtask

   vec_t vecs[10];

   initial begin
      logic [63:0] ra, rb, res;
      logic [1:0]  rop;
      logic        rw;
      int          st;
      bit          ok;

      vecs[0] = '{"div100_7",  2'd0, 1'b0, 64'd100, 64'd7, 64'd14, N64 + 1};
      vecs[1] = '{"rem100_7",  2'd2, 1'b0, 64'd100, 64'd7, 64'd2, N64 + 1};
      vecs[2] = '{"rem_m7_2",  2'd2, 1'b0, -64'sd7, 64'd2, '1, N64 + 1};
      vecs[3] = '{"div_m7_2",  2'd0, 1'b0, -64'sd7, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFD, N64 + 1};
      vecs[4] = '{"divu_z",    2'd1, 1'b0, 64'h1234, 64'd0, '1, 1};
      vecs[5] = '{"remu_z",    2'd3, 1'b0, 64'h1234, 64'd0, 64'h1234, 1};
      vecs[6] = '{"div_ovf",   2'd0, 1'b0, 64'h8000_0000_0000_0000, '1,
                  64'h8000_0000_0000_0000, 1};
      vecs[7] = '{"rem_ovf",   2'd2, 1'b0, 64'h8000_0000_0000_0000, '1,
                  64'd0, 1};
      vecs[8] = '{"divw_ovf",  2'd0, 1'b1, 64'h0000_0000_8000_0000, '1,
                  64'hFFFF_FFFF_8000_0000, 1};
      vecs[9] = '{"remuw_7_3", 2'd3, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd3,
                  64'd1, N32 + 1};

      rst     = 1'b1;
      start_i = 1'b0;
      op_i    = 2'd0;
      word_i  = 1'b0;
      src1_i  = '0;
      src2_i  = '0;
      kill_i  = 1'b0;
      #12;
      chk64("reset_result", result_o, 64'd0);
      chk_int("reset_done", int'(done_o), 0);
      @(negedge clk);
      rst = 1'b0;

      // directed table, back to back
      @(negedge clk);
      foreach (vecs[i])
         do_vec(vecs[i].name, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
                vecs[i].exp, vecs[i].stall);

      // kill in BUSY cycle 10, new DIV the following cycle
      @(negedge clk);
      op_i = 2'd0; word_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd3;
      start_i = 1'b1;
      for (int c = 0; c < 10; c++) @(negedge clk);
      #1;
      chk_int("busy_stall", int'(stall_req_o), 1);
      kill_i = 1'b1;
      #1;
      chk_int("kill_stall", int'(stall_req_o), 0);
      @(negedge clk);
      kill_i = 1'b0;
      chk_int("kill_no_done", int'(done_o), 0);
      do_vec("after_kill", 2'd0, 1'b0, 64'd9, 64'd3, 64'd3, N64 + 1);

      // reset mid-BUSY
      op_i = 2'd0; word_i = 1'b0; src1_i = 64'd12345; src2_i = 64'd7;
      start_i = 1'b1;
      for (int c = 0; c < 20; c++) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk64("rst_result", result_o, 64'd0);
      chk_int("rst_done", int'(done_o), 0);
      chk_int("rst_stall", int'(stall_req_o), 0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_vec("after_rst", 2'd0, 1'b0, 64'd9, 64'd3, 64'd3, N64 + 1);

      // random ops against the reference model
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         rw  = 1'($urandom_range(0, 1));
         ra  = {$urandom(), $urandom()};
         rb  = {$urandom(), $urandom()};
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 64'($urandom_range(1, 50));
            2: begin ra = 64'h8000_0000_0000_0000; rb = '1; end
            3: begin ra = 64'hFFFF_FFFF_8000_0000; rb = '1; end
            4: rb = {32'hFFFF_FFFF, 32'($urandom_range(0, 1000))};
            default: ;
         endcase
         run_op(rop, rw, ra, rb, res, st, ok);
         if (ok) begin
            chk64($sformatf("rand%0d_res", n), res, ref_res(rop, rw, ra, rb));
            chk_int($sformatf("rand%0d_stall", n), st,
                    ref_stall(rop, rw, ra, rb));
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
